// File: rtl/cell_sweep_pkg.sv
// Shared types and truth-table constants for the standard-cell sweep sequencer.
package cell_sweep_pkg;

   // Sweep sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } sweep_state_e;

   // Width of the settle counter; covers the full 1..255 settle range
   localparam int unsigned CNT_W = 8;

   // Expected truth tables, bit i is the output for input vector i (MSB input first)
   localparam logic [7:0] AOI21_TT = 8'h07;   // ZN = ~(A | (B1 & B2))
   localparam logic [3:0] NAND2_TT = 4'h7;    // ZN = ~(A & B)
   localparam logic [3:0] NOR2_TT  = 4'h1;    // ZN = ~(A | B)
   localparam logic [1:0] INV_TT   = 2'h1;    // ZN = ~A

endpackage

// File: rtl/sweep_settle_cnt.sv
// Loadable down-counter with terminal-count flag, used to time the settle window.
module sweep_settle_cnt
   import cell_sweep_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         tc_c
);

   logic [W-1:0] cnt;

   // Load takes priority; decrement stops at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tc_c = (cnt == '0);

endmodule

// File: rtl/cell_sweep_ctrl.sv
// Exhaustive input sweep of a single-output combinational cell with truth-table check.
module cell_sweep_ctrl
   import cell_sweep_pkg::*;
#(
   parameter int unsigned              N_IN   = 3,
   parameter int unsigned              SETTLE = 2,
   parameter logic [(1<<N_IN)-1:0]     EXP_TT = AOI21_TT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [N_IN-1:0] cut_in,
   input  logic            cut_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt,
   output logic            fail_vld,
   output logic [N_IN-1:0] fail_vec
);

   localparam int unsigned           NUM_VEC   = 1 << N_IN;
   localparam int unsigned           ERR_W     = N_IN + 1;
   localparam logic [N_IN-1:0]       LAST_VEC  = N_IN'(NUM_VEC - 1);
   localparam logic [ERR_W-1:0]      ERR_MAX   = ERR_W'(NUM_VEC);
   localparam logic [CNT_W-1:0]      SETTLE_LD = CNT_W'(SETTLE - 1);

   sweep_state_e      state_q;
   sweep_state_e      state_d;
   logic [N_IN-1:0]   vec_q;
   logic              cnt_load;
   logic              cnt_en;
   logic              settle_tc;
   logic              sweep_clr;
   logic              vec_inc;
   logic              do_sample;
   logic              last_sample;
   logic              mismatch;
   logic [ERR_W-1:0]  err_cnt_d;

   // Settle-window timer: loaded on every entry to WAIT
   sweep_settle_cnt #(
      .W (CNT_W)
   ) u_settle (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (SETTLE_LD),
      .en       (cnt_en),
      .tc_c     (settle_tc)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control strobes
   always_comb begin
      state_d     = state_q;
      cnt_load    = 1'b0;
      cnt_en      = 1'b0;
      sweep_clr   = 1'b0;
      vec_inc     = 1'b0;
      do_sample   = 1'b0;
      last_sample = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = WAIT;
               sweep_clr = 1'b1;
               cnt_load  = 1'b1;
            end
         end
         WAIT: begin
            if (settle_tc) begin
               state_d = SAMPLE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         SAMPLE: begin
            do_sample = 1'b1;
            if (vec_q == LAST_VEC) begin
               state_d     = DONE;
               last_sample = 1'b1;
            end else begin
               state_d  = WAIT;
               vec_inc  = 1'b1;
               cnt_load = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Unknown or floating cell output is treated as a mismatch
   assign mismatch  = do_sample && (cut_out !== EXP_TT[vec_q]);
   assign err_cnt_d = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + ERR_W'(1) : err_cnt;

   // Vector, status and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= '0;
         fail_vld <= 1'b0;
         fail_vec <= '0;
      end else begin
         busy <= (state_d != IDLE);
         done <= (state_d == DONE);
         if (sweep_clr) begin
            vec_q    <= '0;
            err_cnt  <= '0;
            fail_vld <= 1'b0;
            pass     <= 1'b0;
         end else begin
            if (vec_inc) begin
               vec_q <= vec_q + N_IN'(1);
            end
            err_cnt <= err_cnt_d;
            if (mismatch && !fail_vld) begin
               fail_vec <= vec_q;
               fail_vld <= 1'b1;
            end
            // Verdict is formed with the final sample included so it is valid alongside done
            if (last_sample) begin
               pass <= (err_cnt_d == '0);
            end
         end
      end
   end

   assign cut_in = vec_q;

endmodule

// File: tb/tb_cell_sweep_ctrl.sv
// Self-checking bench: two sequencer configurations driving behavioural cell models.
module tb_cell_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   int          sel;
   logic [7:0]  fmask;
   int          errors = 0;
   int          checks = 0;

   logic        start1, start2;
   logic [2:0]  cut_in1;
   logic        cut_out1, busy1, done1, pass1, fvld1;
   logic [3:0]  err1;
   logic [2:0]  fvec1;
   logic [1:0]  cut_in2;
   logic        cut_out2, busy2, done2, pass2, fvld2;
   logic [2:0]  err2;
   logic [1:0]  fvec2;

   logic        o_busy, o_done, o_pass, o_fvld;
   logic [3:0]  o_err;
   logic [2:0]  o_fvec, o_cut;

   always #5 clk = ~clk;

   assign start1 = go && (sel == 0);
   assign start2 = go && (sel == 1);

   // Cell models: golden function, with fmask flipping the output of selected vectors
   assign cut_out1 = ~(cut_in1[2] | (cut_in1[1] & cut_in1[0])) ^ fmask[cut_in1];
   assign cut_out2 = ~(cut_in2[1] & cut_in2[0]) ^ fmask[cut_in2];

   cell_sweep_ctrl dut1 (
      .clk (clk), .rst (rst), .start (start1), .cut_in (cut_in1), .cut_out (cut_out1),
      .busy (busy1), .done (done1), .pass (pass1), .err_cnt (err1),
      .fail_vld (fvld1), .fail_vec (fvec1)
   );

   cell_sweep_ctrl #(.N_IN (2), .SETTLE (1), .EXP_TT (4'b0111)) dut2 (
      .clk (clk), .rst (rst), .start (start2), .cut_in (cut_in2), .cut_out (cut_out2),
      .busy (busy2), .done (done2), .pass (pass2), .err_cnt (err2),
      .fail_vld (fvld2), .fail_vec (fvec2)
   );

   always_comb begin
      o_busy = (sel == 0) ? busy1 : busy2;
      o_done = (sel == 0) ? done1 : done2;
      o_pass = (sel == 0) ? pass1 : pass2;
      o_fvld = (sel == 0) ? fvld1 : fvld2;
      o_err  = (sel == 0) ? err1  : {1'b0, err2};
      o_fvec = (sel == 0) ? fvec1 : {1'b0, fvec2};
      o_cut  = (sel == 0) ? cut_in1 : {1'b0, cut_in2};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Mismatches already sampled and visible by cycle k (vector v is sampled at the end of cycle per*(v+1))
   function automatic int exp_err(input logic [7:0] m, input int k, input int per, input int nv);
      int n = 0;
      for (int v = 0; v < nv; v++) begin
         if (m[v] && (per * (v + 1) + 1 <= k)) n++;
      end
      return n;
   endfunction

   function automatic int first_bad(input logic [7:0] m, input int nv);
      for (int v = 0; v < nv; v++) begin
         if (m[v]) return v;
      end
      return 0;
   endfunction

   // One full sweep checked cycle by cycle; extra adds ignored starts and an accepted re-start
   task automatic sweep(input int s, input logic [7:0] m, input bit extra);
      int per, nv, dk, dones, e, tot;
      per   = (s == 0) ? 3 : 2;
      nv    = (s == 0) ? 8 : 4;
      dk    = 1 + nv * per;
      dones = 0;
      sel   = s;
      fmask = m;
      tot   = exp_err(m, dk, per, nv);
      go = 1'b1;
      step();
      go = 1'b0;
      for (int k = 1; k <= dk + 1; k++) begin
         go = extra && ((k == 6) || (k == dk) || (k == dk + 1));
         e  = exp_err(m, k, per, nv);
         chk($sformatf("busy@%0d", k), 32'(o_busy), 32'(k <= dk));
         chk($sformatf("done@%0d", k), 32'(o_done), 32'(k == dk));
         chk($sformatf("cut_in@%0d", k), 32'(o_cut), (k <= per * nv) ? (k - 1) / per : nv - 1);
         chk($sformatf("err_cnt@%0d", k), 32'(o_err), e);
         chk($sformatf("fail_vld@%0d", k), 32'(o_fvld), 32'(e > 0));
         if (e > 0) chk($sformatf("fail_vec@%0d", k), 32'(o_fvec), first_bad(m, nv));
         chk($sformatf("pass@%0d", k), 32'(o_pass), 32'((k >= dk) && (tot == 0)));
         dones += int'(o_done);
         step();
      end
      go = 1'b0;
      chk("done_count", dones, 1);
      if (extra) begin
         chk("restart_busy", 32'(o_busy), 1);
         chk("restart_err", 32'(o_err), 0);
         chk("restart_fvld", 32'(o_fvld), 0);
         chk("restart_pass", 32'(o_pass), 0);
         chk("restart_cut", 32'(o_cut), 0);
         dones = 0;
         for (int k = 1; k <= dk + 1; k++) begin
            if (k == dk) begin
               chk("restart_done", 32'(o_done), 1);
               chk("restart_final_err", 32'(o_err), tot);
               chk("restart_final_pass", 32'(o_pass), 32'(tot == 0));
            end
            dones += int'(o_done);
            step();
         end
         chk("restart_done_count", dones, 1);
      end
   endtask

   initial begin
      int dones;
      rst   = 1'b1;
      go    = 1'b0;
      sel   = 0;
      fmask = 8'h00;
      step();
      step();
      chk("rst_cut_in", 32'(cut_in1), 0);
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_done", 32'(done1), 0);
      chk("rst_pass", 32'(pass1), 0);
      chk("rst_err", 32'(err1), 0);
      chk("rst_fvld", 32'(fvld1), 0);
      chk("rst_fvec", 32'(fvec1), 0);
      chk("rst_busy2", 32'(busy2), 0);
      rst = 1'b0;
      step();

      // Good cell, stuck-at-1 cell, single flipped vector
      sweep(0, 8'h00, 1'b0);
      sweep(0, 8'hF8, 1'b0);
      repeat (3) step();
      chk("idle_err", 32'(err1), 5);
      chk("idle_fvld", 32'(fvld1), 1);
      chk("idle_fvec", 32'(fvec1), 3);
      chk("idle_pass", 32'(pass1), 0);
      chk("idle_cut", 32'(cut_in1), 7);
      chk("idle_busy", 32'(busy1), 0);
      sweep(0, 8'h20, 1'b0);

      // Ignored starts during the sweep and in DONE, then a re-start right after
      sweep(0, 8'h00, 1'b1);

      // NAND2 configuration
      sweep(1, 8'h00, 1'b0);
      sweep(1, 8'h0A, 1'b0);

      // Random fault patterns
      for (int i = 0; i < 6; i++) sweep(0, 8'($urandom), 1'b0);
      for (int i = 0; i < 4; i++) sweep(1, 8'($urandom_range(0, 15)), 1'b0);

      // Reset mid-sweep
      sel   = 0;
      fmask = 8'hF8;
      go = 1'b1;
      step();
      go = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      chk("abort_cut_in", 32'(cut_in1), 0);
      chk("abort_busy", 32'(busy1), 0);
      chk("abort_done", 32'(done1), 0);
      chk("abort_pass", 32'(pass1), 0);
      chk("abort_err", 32'(err1), 0);
      chk("abort_fvld", 32'(fvld1), 0);
      chk("abort_fvec", 32'(fvec1), 0);
      rst   = 1'b0;
      dones = 0;
      for (int k = 0; k < 30; k++) begin
         dones += int'(done1);
         step();
      end
      chk("abort_no_done", dones, 0);
      chk("abort_idle_busy", 32'(busy1), 0);

      // Reset wins over a simultaneous start, and the start is not retained
      rst = 1'b1;
      go  = 1'b1;
      step();
      rst = 1'b0;
      go  = 1'b0;
      chk("rst_start_busy", 32'(busy1), 0);
      step();
      chk("rst_start_noqueue", 32'(busy1), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cell_sweep_ctrl.md
# cell_sweep_ctrl

Sequencer that drives a single-output combinational standard cell (default AOI21_X4) through every input combination, waits a programmable settle time per vector, samples the cell output and checks it against an expected truth table. It sits between a start/status interface and the cell under test (CUT), and replaces hand-written per-vector stimulus with a reusable, clocked exhaustive sweep.

## Interface
- `N_IN`, 3, number of CUT inputs; sweep covers 2^N_IN vectors.
- `SETTLE`, 2, cycles the vector is held before sampling; legal range is 1..255.
- `EXP_TT`, 8'h07, expected output; bit i is the required output for input vector i.
  - Default is AOI21: ZN = ~(A | (B1 & B2)).
  - Vector bit order is {A, B1, B2}, A is the MSB.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
- `cut_in`  out  N_IN  input vector driven to the CUT.
- `cut_out`  in  1  CUT output.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive of the `done` cycle.
- `done`  out  1  one-cycle pulse at the end of a sweep.
- `pass`  out  1  1 when err_cnt == 0 at the end of a sweep; held until the next accepted `start`.
- `err_cnt`  out  N_IN+1  number of mismatching vectors; saturates at 2^N_IN.
- `fail_vld`  out  1  at least one mismatch has occurred in this sweep.
- `fail_vec`  out  N_IN  the first mismatching vector; valid only when `fail_vld` is high.

## Operation
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- **IDLE**
  - `start` high → WAIT.
  - Same edge: vec←0, cnt←0, err_cnt←0, fail_vld←0, pass←0.
- **WAIT**
  - `cut_in` = vec.
  - cnt == SETTLE-1 → SAMPLE; otherwise cnt++.
- **SAMPLE**
  - mismatch = (cut_out !== EXP_TT[vec]). An X or Z on `cut_out` counts as a mismatch.
  - On mismatch: err_cnt++.
  - On mismatch with fail_vld == 0: fail_vec←vec, fail_vld←1.
  - vec == 2^N_IN-1 → DONE.
  - Otherwise → WAIT with vec++ and cnt←0.
- **DONE**
  - `done` = 1.
  - pass←(err_cnt == 0), where err_cnt already includes the final SAMPLE.
  - → IDLE unconditionally.
- `start` outside IDLE is ignored and does not queue.
- `cut_in` holds its last vector in DONE and IDLE. It returns to 0 only on reset or the next accepted `start`.
- Results (`pass`, `err_cnt`, `fail_vld`, `fail_vec`) remain stable in IDLE until the next accepted `start`.

## Timing
- Reset values: state = IDLE, `cut_in` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_cnt` = 0, `fail_vld` = 0, `fail_vec` = 0.
- `rst` asserted mid-sweep returns the block to IDLE at the next edge with the reset values above. No `done` is produced for the aborted sweep.
- All outputs are registered.
- Each vector occupies SETTLE+1 cycles: SETTLE in WAIT, 1 in SAMPLE.
- `start` sampled high at edge 0 gives:
  - `busy` high from cycle 1.
  - `done` high in cycle 1 + 2^N_IN·(SETTLE+1). With defaults this is cycle 25.
  - `busy` low from the cycle after that.
- `cut_in` changes only on the edge that enters WAIT. The CUT therefore sees SETTLE full cycles of stable input before the sample.
- `start` high in the DONE cycle is ignored. The earliest accepted re-start is the first IDLE cycle after DONE.
- `start` and `rst` high together: `rst` wins.

## Structure
- Package `cell_sweep_pkg` holds:
  - the FSM state enum;
  - the localparam `AOI21_TT = 8'h07`;
  - truth-table constants for other cells as they are added.
- Sub-module `sweep_settle_cnt`: a loadable down-counter with a terminal-count flag, reused for the WAIT timing.
- Everything else stays in the top module.

## Test plan
- Correct AOI21_X4 as CUT, defaults, `start` at cycle 0:
  - `cut_in` steps through 0..7, each held 3 cycles.
  - `done` in cycle 25 with `pass` = 1, `err_cnt` = 0, `fail_vld` = 0.
- Model with ZN stuck-at-1:
  - mismatches at vectors 3..7, giving `err_cnt` = 5.
  - `fail_vec` = 3'b011, `fail_vld` = 1, `pass` = 0.
- CUT output driven X for vector 5 only: `err_cnt` = 1, `fail_vec` = 3'b101.
- `start` pulsed again at cycles 6 and 25:
  - both are ignored; exactly one `done` occurs.
  - A `start` at cycle 26 begins a new sweep and clears the previous results in cycle 27.
- `rst` asserted at cycle 10 during a sweep: all outputs reach reset values by cycle 11 and no `done` pulse appears.
- SETTLE = 1 with `N_IN` = 2 and `EXP_TT` = 4'b0111 (NAND2): `done` in cycle 9 with `pass` = 1.
